// File: rtl/ysyx_25040111_csr_pkg.sv
// Shared CSR addresses, mstatus field positions and trap-sequencer state encoding.
// Also holds the mstatus rewrite rules applied on trap entry and on mret.
package ysyx_25040111_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T_EPC,
      ST_T_STAT,
      ST_T_VEC,
      ST_M_RSTAT,
      ST_M_WSTAT,
      ST_M_EPC
   } trap_state_e;

   // Trap entry stacks the interrupt enable and disables interrupts.
   function automatic logic [31:0] trap_mstatus(input logic [31:0] s, input logic [1:0] mpp);
      logic [31:0] r;
      r = s;
      r[MSTATUS_MPIE] = s[MSTATUS_MIE];
      r[MSTATUS_MIE] = 1'b0;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
      return r;
   endfunction

   function automatic logic [31:0] mret_mstatus(input logic [31:0] s, input logic [1:0] mpp);
      logic [31:0] r;
      r = s;
      r[MSTATUS_MIE] = s[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
      return r;
   endfunction

endpackage

// File: rtl/ysyx_25040111_csr_port_mux.sv
// Selects who drives the single CSR port: the instruction datapath or the trap sequencer.
// When neither is enabled the port is idle and the instruction sees zero read data.
module ysyx_25040111_csr_port_mux (
   input  logic        sel_seq,
   input  logic        inst_en,
   input  logic        inst_wen,
   input  logic [11:0] inst_waddr,
   input  logic [31:0] inst_wdata,
   input  logic        inst_ren,
   input  logic [11:0] inst_raddr,
   output logic [31:0] inst_rdata,
   input  logic        seq_wen,
   input  logic [11:0] seq_waddr,
   input  logic [31:0] seq_wdata,
   input  logic        seq_ren,
   input  logic [11:0] seq_raddr,
   output logic        csr_wen,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic        csr_ren,
   output logic [11:0] csr_raddr,
   input  logic [31:0] csr_rdata
);

   always_comb begin
      csr_wen    = 1'b0;
      csr_waddr  = '0;
      csr_wdata  = '0;
      csr_ren    = 1'b0;
      csr_raddr  = '0;
      inst_rdata = '0;
      if (sel_seq) begin
         csr_wen   = seq_wen;
         csr_waddr = seq_waddr;
         csr_wdata = seq_wdata;
         csr_ren   = seq_ren;
         csr_raddr = seq_raddr;
      end else if (inst_en) begin
         csr_wen    = inst_wen;
         csr_waddr  = inst_waddr;
         csr_wdata  = inst_wdata;
         csr_ren    = inst_ren;
         csr_raddr  = inst_raddr;
         inst_rdata = csr_rdata;
      end
   end

endmodule

// File: rtl/ysyx_25040111_trap_seq.sv
// Trap-entry / mret CSR sequencer with instruction-port arbitration and PC redirect.
// Define TRAP_VECTORED_EN to honour mtvec vectored mode for interrupt causes.
module ysyx_25040111_trap_seq
   import ysyx_25040111_csr_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [1:0]  MPP_RESET = 2'b11
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            trap_valid,
   output logic            trap_ready,
   input  logic [3:0]      trap_cause,
   input  logic            trap_intr,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret_valid,
   output logic            mret_ready,
   input  logic            inst_wen,
   input  logic [11:0]     inst_waddr,
   input  logic [XLEN-1:0] inst_wdata,
   input  logic            inst_ren,
   input  logic [11:0]     inst_raddr,
   output logic [XLEN-1:0] inst_rdata,
   output logic            inst_stall,
   output logic            csr_wen,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            csr_ren,
   output logic [11:0]     csr_raddr,
   input  logic [XLEN-1:0] csr_rdata,
   output logic            csr_err,
   output logic [3:0]      csr_errtp,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   trap_state_e     state_q, state_d;
   logic [3:0]      cause_q, cause_d;
   logic            intr_q, intr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] stat_q, stat_d;

   logic            sel_seq, inst_en;
   logic            seq_wen, seq_ren;
   logic [11:0]     seq_waddr, seq_raddr;
   logic [XLEN-1:0] seq_wdata;
   logic [XLEN-1:0] vec_base;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cause_q <= '0;
         intr_q  <= 1'b0;
         pc_q    <= '0;
         stat_q  <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         intr_q  <= intr_d;
         pc_q    <= pc_d;
         stat_q  <= stat_d;
      end
   end

   assign vec_base = {csr_rdata[XLEN-1:2], 2'b00};

`ifndef TRAP_VECTORED_EN
   logic unused_intr;
   assign unused_intr = intr_q;
`endif

   always_comb begin
      state_d        = state_q;
      cause_d        = cause_q;
      intr_d         = intr_q;
      pc_d           = pc_q;
      stat_d         = stat_q;
      trap_ready     = 1'b0;
      mret_ready     = 1'b0;
      sel_seq        = 1'b1;
      inst_en        = 1'b0;
      seq_wen        = 1'b0;
      seq_waddr      = '0;
      seq_wdata      = '0;
      seq_ren        = 1'b0;
      seq_raddr      = '0;
      csr_err        = 1'b0;
      csr_errtp      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      unique case (state_q)
         ST_IDLE: begin
            sel_seq    = 1'b0;
            inst_en    = 1'b1;
            trap_ready = 1'b1;
            mret_ready = !trap_valid;
            if (trap_valid) begin
               cause_d = trap_cause;
               intr_d  = trap_intr;
               pc_d    = trap_pc;
               state_d = ST_T_EPC;
            end else if (mret_valid) begin
               state_d = ST_M_RSTAT;
            end
         end
         ST_T_EPC: begin
            seq_wen   = 1'b1;
            seq_waddr = CSR_MEPC;
            seq_wdata = pc_q;
            csr_err   = 1'b1;
            csr_errtp = cause_q;
            seq_ren   = 1'b1;
            seq_raddr = CSR_MSTATUS;
            stat_d    = csr_rdata;
            state_d   = ST_T_STAT;
         end
         ST_T_STAT: begin
            seq_wen   = 1'b1;
            seq_waddr = CSR_MSTATUS;
            seq_wdata = trap_mstatus(stat_q, MPP_RESET);
            state_d   = ST_T_VEC;
         end
         ST_T_VEC: begin
            seq_ren        = 1'b1;
            seq_raddr      = CSR_MTVEC;
            redirect_valid = 1'b1;
            redirect_pc    = vec_base;
`ifdef TRAP_VECTORED_EN
            if (csr_rdata[1:0] == 2'b01 && intr_q)
               redirect_pc = vec_base + {{(XLEN-6){1'b0}}, cause_q, 2'b00};
`endif
            state_d        = ST_IDLE;
         end
         ST_M_RSTAT: begin
            seq_ren   = 1'b1;
            seq_raddr = CSR_MSTATUS;
            stat_d    = csr_rdata;
            state_d   = ST_M_WSTAT;
         end
         ST_M_WSTAT: begin
            seq_wen   = 1'b1;
            seq_waddr = CSR_MSTATUS;
            seq_wdata = mret_mstatus(stat_q, MPP_RESET);
            state_d   = ST_M_EPC;
         end
         ST_M_EPC: begin
            seq_ren        = 1'b1;
            seq_raddr      = CSR_MEPC;
            redirect_valid = 1'b1;
            redirect_pc    = csr_rdata;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Reset cycle: drop any in-flight CSR write and present the idle handshake only.
      if (reset) begin
         trap_ready     = 1'b1;
         mret_ready     = 1'b1;
         sel_seq        = 1'b0;
         inst_en        = 1'b0;
         csr_err        = 1'b0;
         csr_errtp      = '0;
         redirect_valid = 1'b0;
         redirect_pc    = '0;
      end
   end

   assign inst_stall = sel_seq;
   assign busy       = (state_q != ST_IDLE) && !reset;

   ysyx_25040111_csr_port_mux u_port_mux (
      .sel_seq    (sel_seq),
      .inst_en    (inst_en),
      .inst_wen   (inst_wen),
      .inst_waddr (inst_waddr),
      .inst_wdata (inst_wdata),
      .inst_ren   (inst_ren),
      .inst_raddr (inst_raddr),
      .inst_rdata (inst_rdata),
      .seq_wen    (seq_wen),
      .seq_waddr  (seq_waddr),
      .seq_wdata  (seq_wdata),
      .seq_ren    (seq_ren),
      .seq_raddr  (seq_raddr),
      .csr_wen    (csr_wen),
      .csr_waddr  (csr_waddr),
      .csr_wdata  (csr_wdata),
      .csr_ren    (csr_ren),
      .csr_raddr  (csr_raddr),
      .csr_rdata  (csr_rdata)
   );

endmodule

// File: tb/tb_ysyx_25040111_trap_seq.sv
// Scoreboard bench for ysyx_25040111_trap_seq: a CSR-file model sits on the CSR port,
// issued traps/mrets push expected redirects, and a monitor checks them as they appear.
module tb_ysyx_25040111_trap_seq;
   import ysyx_25040111_csr_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        trap_valid = 1'b0, trap_intr = 1'b0, mret_valid = 1'b0;
   logic [3:0]  trap_cause = '0;
   logic [31:0] trap_pc = '0;
   logic        inst_wen = 1'b0, inst_ren = 1'b0;
   logic [11:0] inst_waddr = '0, inst_raddr = '0;
   logic [31:0] inst_wdata = '0;
   logic        trap_ready, mret_ready, inst_stall, csr_wen, csr_ren, csr_err;
   logic        redirect_valid, busy;
   logic [31:0] inst_rdata, csr_wdata, csr_rdata, redirect_pc;
   logic [11:0] csr_waddr, csr_raddr;
   logic [3:0]  csr_errtp;

   ysyx_25040111_trap_seq dut (
      .clock(clock), .reset(reset),
      .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_cause(trap_cause),
      .trap_intr(trap_intr), .trap_pc(trap_pc),
      .mret_valid(mret_valid), .mret_ready(mret_ready),
      .inst_wen(inst_wen), .inst_waddr(inst_waddr), .inst_wdata(inst_wdata),
      .inst_ren(inst_ren), .inst_raddr(inst_raddr), .inst_rdata(inst_rdata),
      .inst_stall(inst_stall),
      .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_err(csr_err), .csr_errtp(csr_errtp),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // CSR file environment: combinational read with same-address write forwarding.
   logic [31:0] csr_mem [0:4095];
   always_comb csr_rdata = (csr_wen && csr_waddr == csr_raddr) ? csr_wdata : csr_mem[csr_raddr];
   always @(posedge clock) begin
      if (csr_wen) csr_mem[csr_waddr] <= csr_wdata;
      if (csr_err) csr_mem[CSR_MCAUSE] <= {28'b0, csr_errtp};
   end

   typedef struct {
      logic [31:0] pc;
      int          at;
      logic        is_trap;
      logic [31:0] ms;
      logic [31:0] epc;
      logic [31:0] cause;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   int chk_cnt = 0;
   int pass_cnt = 0;
   logic [31:0] m_mstatus = '0, m_mtvec = '0, m_mepc = '0, m_mcause = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference rules written from the architectural description of mstatus.
   function automatic logic [31:0] ref_trap_status(input logic [31:0] s);
      logic mie;
      mie = (s / 8) % 2 == 1;
      s = s & ~32'h0000_1888;
      return s | (mie ? 32'h80 : 32'h0) | 32'h1800;
   endfunction

   function automatic logic [31:0] ref_mret_status(input logic [31:0] s);
      logic mpie;
      mpie = (s / 128) % 2 == 1;
      s = s & ~32'h0000_1888;
      return s | (mpie ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
   endfunction

   function automatic logic [31:0] ref_trap_target(input logic [31:0] tvec, input logic intr,
                                                    input logic [3:0] cause);
      logic [31:0] base;
      base = tvec - (tvec % 4);
`ifdef TRAP_VECTORED_EN
      if (tvec % 4 == 1 && intr) return base + 4 * cause;
`else
      if (intr && 1'b0) return 32'h0;
`endif
      return base;
   endfunction

   always @(negedge clock) begin
      if (!reset && redirect_valid) begin
         if (exp_q.size() == 0) checkOutput("unexpected_redirect", redirect_pc, 32'hffff_ffff);
         else begin
            mon_e = exp_q.pop_front();
            checkOutput("redirect_pc", redirect_pc, mon_e.pc);
            checkOutput("redirect_cycle", cyc, mon_e.at);
            checkOutput("mstatus_after", csr_mem[CSR_MSTATUS], mon_e.ms);
            checkOutput("mepc_after", csr_mem[CSR_MEPC], mon_e.epc);
            if (mon_e.is_trap) checkOutput("mcause_after", csr_mem[CSR_MCAUSE], mon_e.cause);
         end
      end
   end

   task automatic waitIdle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (!busy) return;
      end
      checkOutput("idle_timeout", busy, 0);
   endtask

   task automatic csrWrite(input logic [11:0] a, input logic [31:0] d);
      @(negedge clock);
      inst_wen = 1'b1; inst_waddr = a; inst_wdata = d;
      #1;
      checkOutput("pass_wen", csr_wen, 1);
      checkOutput("pass_waddr", csr_waddr, a);
      checkOutput("pass_wdata", csr_wdata, d);
      checkOutput("pass_stall", inst_stall, 0);
      @(posedge clock); #1 inst_wen = 1'b0;
      case (a)
         CSR_MSTATUS: m_mstatus = d;
         CSR_MTVEC:   m_mtvec = d;
         CSR_MEPC:    m_mepc = d;
         CSR_MCAUSE:  m_mcause = d;
         default: ;
      endcase
   endtask

   task automatic csrReadCheck(input string name, input logic [11:0] a, input logic [31:0] exp);
      @(negedge clock);
      inst_ren = 1'b1; inst_raddr = a;
      #1 checkOutput(name, inst_rdata, exp);
      @(posedge clock); #1 inst_ren = 1'b0;
   endtask

   task automatic pushTrap(input int k, input logic [3:0] c, input logic i, input logic [31:0] p);
      exp_t e;
      m_mstatus = ref_trap_status(m_mstatus);
      m_mepc = p;
      m_mcause = {28'b0, c};
      e.pc = ref_trap_target(m_mtvec, i, c);
      e.at = k + 3; e.is_trap = 1'b1; e.ms = m_mstatus; e.epc = m_mepc; e.cause = m_mcause;
      exp_q.push_back(e);
   endtask

   task automatic pushMret(input int k);
      exp_t e;
      m_mstatus = ref_mret_status(m_mstatus);
      e.pc = m_mepc; e.at = k + 3; e.is_trap = 1'b0;
      e.ms = m_mstatus; e.epc = m_mepc; e.cause = m_mcause;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic is_trap, input logic [3:0] c, input logic i,
                                input logic [31:0] p);
      @(negedge clock);
      if (is_trap) begin
         trap_valid = 1'b1; trap_cause = c; trap_intr = i; trap_pc = p;
         #1 checkOutput("trap_ready", trap_ready, 1);
         pushTrap(cyc, c, i, p);
      end else begin
         mret_valid = 1'b1;
         #1 checkOutput("mret_ready", mret_ready, 1);
         pushMret(cyc);
      end
      @(posedge clock); #1 trap_valid = 1'b0; mret_valid = 1'b0;
   endtask

   int k;

   initial begin
      // Reset state.
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_trap_ready", trap_ready, 1);
      checkOutput("rst_mret_ready", mret_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_redirect", redirect_valid, 0);
      checkOutput("rst_csr_wen", csr_wen, 0);
      @(posedge clock); #1 reset = 1'b0;

      // Pass-through and the documented trap example.
      csrWrite(CSR_MTVEC, 32'h8000_0100);
      csrReadCheck("read_mtvec", CSR_MTVEC, 32'h8000_0100);
      csrWrite(CSR_MSTATUS, 32'h0000_1808);
      csrWrite(CSR_MEPC, 32'h0);
      csrWrite(CSR_MCAUSE, 32'h0);
      applyStimulus(1'b1, 4'd11, 1'b0, 32'h8000_0040);
      waitIdle();
      checkOutput("ex_trap_status", m_mstatus, 32'h0000_1880);
      csrReadCheck("ex_trap_mstatus", CSR_MSTATUS, 32'h0000_1880);

      // Mret example with busy/stall checks while the instruction port is hammered.
      csrWrite(CSR_MEPC, 32'h8000_0044);
      applyStimulus(1'b0, 4'd0, 1'b0, 32'h0);
      inst_wen = 1'b1; inst_waddr = CSR_MTVEC; inst_wdata = 32'hdead_beef;
      inst_ren = 1'b1; inst_raddr = CSR_MTVEC;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkOutput("mret_busy", busy, 1);
         checkOutput("mret_stall", inst_stall, 1);
         checkOutput("mret_inst_rdata", inst_rdata, 0);
      end
      #1 inst_wen = 1'b0; inst_ren = 1'b0;
      @(negedge clock);
      checkOutput("mret_done_busy", busy, 0);
      csrReadCheck("ex_mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
      csrReadCheck("mtvec_untouched", CSR_MTVEC, 32'h8000_0100);

      // Simultaneous trap and mret: trap wins, mret follows right after redirect.
      @(negedge clock);
      trap_valid = 1'b1; trap_cause = 4'd3; trap_intr = 1'b0; trap_pc = 32'h8000_0200;
      mret_valid = 1'b1;
      #1;
      checkOutput("both_trap_ready", trap_ready, 1);
      checkOutput("both_mret_ready", mret_ready, 0);
      k = cyc;
      pushTrap(k, 4'd3, 1'b0, 32'h8000_0200);
      @(posedge clock); #1 trap_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (mret_ready) break;
      end
      checkOutput("mret_after_redirect", cyc, k + 4);
      pushMret(cyc);
      @(posedge clock); #1 mret_valid = 1'b0;
      waitIdle();

      // Reset in T_STAT: mepc/mcause already written, mstatus must stay.
      @(negedge clock);
      trap_valid = 1'b1; trap_cause = 4'd5; trap_intr = 1'b0; trap_pc = 32'h8000_0300;
      @(posedge clock); #1 trap_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("rst_mid_csr_wen", csr_wen, 0);
      checkOutput("rst_mid_redirect", redirect_valid, 0);
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_trap_ready", trap_ready, 1);
      m_mepc = 32'h8000_0300; m_mcause = 32'd5;
      repeat (4) @(negedge clock);
      csrReadCheck("rst_mid_mstatus", CSR_MSTATUS, m_mstatus);
      csrReadCheck("rst_mid_mepc", CSR_MEPC, m_mepc);
      csrReadCheck("rst_mid_mcause", CSR_MCAUSE, m_mcause);

      // Vectored mtvec with an interrupt cause.
      csrWrite(CSR_MTVEC, 32'h8000_0101);
      applyStimulus(1'b1, 4'd7, 1'b1, 32'h8000_0400);
      waitIdle();
`ifdef TRAP_VECTORED_EN
      checkOutput("vec_model", ref_trap_target(32'h8000_0101, 1'b1, 4'd7), 32'h8000_011c);
`else
      checkOutput("vec_model", ref_trap_target(32'h8000_0101, 1'b1, 4'd7), 32'h8000_0100);
`endif

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1) csrWrite(CSR_MSTATUS, $urandom);
         if ($urandom_range(0, 2) == 0) csrWrite(CSR_MEPC, $urandom);
         if ($urandom_range(0, 2) == 0)
            csrWrite(CSR_MTVEC, {$urandom_range(32'h0, 32'h3fff_ffff), 2'b00} |
                                {30'b0, 1'b0, 1'($urandom_range(0, 1))});
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), $urandom);
         waitIdle();
      end

      repeat (3) @(negedge clock);
      checkOutput("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
